// File: rtl/pipe_addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Sign-bit and flag fields exist in the stage record only when PIPE_ADDSUB_FLAGS_EN is defined.
package pipe_addsub_pkg;

  localparam int MAX_N = 64;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // Operands are kept right-aligned: each stage consumes the low slice and shifts the rest down.
  typedef struct packed {
    logic             valid;
    logic [MAX_N-1:0] sum;
    logic [MAX_N-1:0] a;
    logic [MAX_N-1:0] b;
    logic             carry;
`ifdef PIPE_ADDSUB_FLAGS_EN
    logic             sign_a;
    logic             sign_b;
    logic             ovf;
    logic             zero;
`endif
  } stage_t;

endpackage

// File: rtl/pipe_addsub_slice.sv
// W-bit combinational ripple slice built from the shared full-adder cell.
module addsub_slice
  import pipe_addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
    end
    co = c[W];
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit add/subtract, STAGES slices, valid/ready on both sides.
// Build option PIPE_ADDSUB_FLAGS_EN adds registered ovf/zero; otherwise both are tied low.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = slice_width(N, STAGES);

  stage_t stg_q [STAGES];
  stage_t stg_d [STAGES];

  logic [STAGES-1:0]        adv;
  logic [STAGES-1:0]        load;
  logic [W-1:0]             sl_a  [STAGES];
  logic [W-1:0]             sl_b  [STAGES];
  logic [STAGES-1:0]        sl_ci;
  logic [STAGES-1:0][W-1:0] sl_s;
  logic [STAGES-1:0]        sl_co;
  logic [MAX_N-1:0]         a_ext;
  logic [MAX_N-1:0]         b_ext;
  logic                     xfer_in;

  always_comb begin
    a_ext        = '0;
    b_ext        = '0;
    a_ext[N-1:0] = A;
    case (sub)
      OP_ADD:  b_ext[N-1:0] = B;
      OP_SUB:  b_ext[N-1:0] = ~B;
      default: b_ext[N-1:0] = B;
    endcase
  end

  // A stage moves on when its successor is empty or is itself moving on.
  always_comb begin
    adv            = '0;
    load           = '0;
    adv[STAGES-1]  = stg_q[STAGES-1].valid && out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = stg_q[k].valid && (!stg_q[k+1].valid || adv[k+1]);
    end
    load[0] = xfer_in;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  assign in_ready = !stg_q[0].valid || adv[0];
  assign xfer_in  = in_valid && in_ready;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        sl_a[k]  = a_ext[W-1:0];
        sl_b[k]  = b_ext[W-1:0];
        sl_ci[k] = cin;
      end else begin
        sl_a[k]  = stg_q[k-1].a[W-1:0];
        sl_b[k]  = stg_q[k-1].b[W-1:0];
        sl_ci[k] = stg_q[k-1].carry;
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    addsub_slice #(.W(W)) u_slice (
      .a  (sl_a[g]),
      .b  (sl_b[g]),
      .ci (sl_ci[g]),
      .s  (sl_s[g]),
      .co (sl_co[g])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k]       = '0;
      stg_d[k].valid = 1'b1;
      stg_d[k].carry = sl_co[k];
      if (k == 0) begin
        stg_d[k].a = a_ext >> W;
        stg_d[k].b = b_ext >> W;
`ifdef PIPE_ADDSUB_FLAGS_EN
        stg_d[k].sign_a = A[N-1];
        stg_d[k].sign_b = b_ext[N-1];
`endif
      end else begin
        stg_d[k].a   = stg_q[k-1].a >> W;
        stg_d[k].b   = stg_q[k-1].b >> W;
        stg_d[k].sum = stg_q[k-1].sum;
`ifdef PIPE_ADDSUB_FLAGS_EN
        stg_d[k].sign_a = stg_q[k-1].sign_a;
        stg_d[k].sign_b = stg_q[k-1].sign_b;
`endif
      end
      stg_d[k].sum[k*W +: W] = sl_s[k];
    end
`ifdef PIPE_ADDSUB_FLAGS_EN
    stg_d[STAGES-1].zero = ~|stg_d[STAGES-1].sum[N-1:0];
    stg_d[STAGES-1].ovf  = (stg_d[STAGES-1].sign_a == stg_d[STAGES-1].sign_b) &&
                           (stg_d[STAGES-1].sum[N-1] != stg_d[STAGES-1].sign_a);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          stg_q[k] <= stg_d[k];
        end else if (adv[k]) begin
          stg_q[k].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = stg_q[STAGES-1].valid;
  assign sum       = stg_q[STAGES-1].sum[N-1:0];
  assign cout      = stg_q[STAGES-1].carry;

`ifdef PIPE_ADDSUB_FLAGS_EN
  assign ovf  = stg_q[STAGES-1].ovf;
  assign zero = stg_q[STAGES-1].zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: hand-computed directed vectors, streamed ops against a 33-bit reference,
// backpressure, and reset with ops in flight. Flag expectations follow PIPE_ADDSUB_FLAGS_EN.
module tb_pipe_addsub;

  localparam int N      = 32;
  localparam int STAGES = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [N-1:0] op_a      = '0;
  logic [N-1:0] op_b      = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected record: {zero, ovf, cout, sum}
  logic [N+2:0] exp_q [$];
  logic [N+2:0] exp_e;
  logic         prev_stall = 1'b0;
  logic [N+3:0] prev_out   = '0;

  always #5 clk = ~clk;

  pipe_addsub #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (op_a),
    .B         (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [N+2:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic c, input logic s);
    logic [N-1:0] bb;
    logic [N:0]   full;
    logic         v;
    logic         z;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, c};
    v    = 1'b0;
    z    = 1'b0;
`ifdef PIPE_ADDSUB_FLAGS_EN
    v = (a[N-1] == bb[N-1]) && (full[N-1] != a[N-1]);
    z = (full[N-1:0] == '0);
`endif
    return {z, v, full};
  endfunction

  // Scoreboard: decisions taken at negedge describe the transfers of the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_model", in_ready, !(exp_q.size() == STAGES && !out_ready));
      if (prev_stall) check("hold_stable", {out_valid, zero, ovf, cout, sum}, prev_out);
      if (exp_q.size() == 0) check("stale_out", out_valid, 1'b0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("sb_sum",  sum,  exp_e[N-1:0]);
        check("sb_cout", cout, exp_e[N]);
        check("sb_ovf",  ovf,  exp_e[N+1]);
        check("sb_zero", zero, exp_e[N+2]);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_op(op_a, op_b, cin, sub));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, zero, ovf, cout, sum};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c, input logic s, input logic [N-1:0] e_sum,
                         input logic e_cout, input logic e_ovf, input logic e_zero);
    int lat;
`ifndef PIPE_ADDSUB_FLAGS_EN
    e_ovf  = 1'b0;
    e_zero = 1'b0;
`endif
    op_a = a; op_b = b; cin = c; sub = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, STAGES);
    check({tag, "_sum"},  sum,  e_sum);
    check({tag, "_cout"}, cout, e_cout);
    check({tag, "_ovf"},  ovf,  e_ovf);
    check({tag, "_zero"}, zero, e_zero);
  endtask

  task automatic new_op();
    op_a = $urandom;
    op_b = $urandom;
    cin  = 1'($urandom_range(1));
    sub  = 1'($urandom_range(1));
  endtask

  task automatic stream(input int n_ops, input int rdy_pct, output int stalls);
    int sent;
    int cyc;
    sent   = 0;
    cyc    = 0;
    stalls = 0;
    new_op();
    in_valid = 1'b1;
    while (sent < n_ops && cyc < 5000) begin
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (in_ready) begin
        sent++;
        tick();
        if (sent < n_ops) new_op();
      end else begin
        stalls++;
        tick();
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_sent", sent, n_ops);
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && cyc < 500) begin
      tick();
      cyc++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int stalls;
    int cnt;
    int n_rst;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum",       sum,       '0);
    check("rst_cout",      cout,      1'b0);
    check("rst_ovf",       ovf,       1'b0);
    check("rst_zero",      zero,      1'b0);

    run_one("wrap",    32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    run_one("neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("cin_add", 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_one("sub_eq",  32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("carry_x", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    drain("drain_directed");

    // Fill every stage with the output blocked, then release while offering a new op.
    stream(STAGES, 0, stalls);
    check("fill_stalls", stalls, 0);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    repeat (3) tick();
    new_op();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check("full_pass_through", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    drain("drain_full");

    stream(100, 100, stalls);
    check("stream_no_stall", stalls, 0);
    drain("drain_stream");

    stream(200, 50, stalls);
    drain("drain_random");

    // Reset with ops still in flight: nothing may emerge afterwards.
    n_rst = (STAGES < 3) ? STAGES : 3;
    stream(n_rst, 0, stalls);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready",  in_ready,  1'b1);
    out_ready = 1'b1;
    cnt = 0;
    repeat (2 * STAGES + 4) begin
      if (out_valid) cnt++;
      tick();
    end
    check("midrst_no_output", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit for the RV32I datapath. It splits an N-bit carry chain into STAGES equal slices with a register boundary between each slice, so the adder can close timing at higher clock rates. It uses a valid/ready handshake with full backpressure and reports carry-out, signed overflow and zero. It serves as the drop-in wide adder for ALU and address-generation paths that can tolerate fixed latency.

## Interface
- N, 32, operand/result width in bits
- STAGES, 4, pipeline slices; N % STAGES == 0 required, 1 ≤ STAGES ≤ N
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands presented
- in_ready  output  1  unit accepts operands this cycle
- A  input  N  operand A
- B  input  N  operand B
- cin  input  1  carry-in (add) / not-borrow-in (sub)
- sub  input  1  0: A+B+cin; 1: A+~B+cin
- out_valid  output  1  result presented
- out_ready  input  1  downstream accepts result
- sum  output  N  result
- cout  output  1  carry-out of bit N-1
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

## Operation
- Slice width W = N/STAGES. Stage k computes result bits [k·W+W-1 : k·W] from the registered carry of stage k-1. Stage 0 uses cin.
- At stage 0 entry, B is conditionally inverted by sub (B ^ {N{sub}}). The caller drives cin=1 with sub=1 for a plain A−B.
- Unprocessed operand upper bits and completed lower sum bits travel alongside each slice in stage registers.
- Each stage holds one valid bit. Stage k advances when it is valid and (stage k+1 is empty or stage k+1 advances). The last stage advances on out_valid && out_ready.
- in_ready = !valid[0] || advance[0]. A transfer occurs on in_valid && in_ready.
- ovf = (A[N-1] == B'[N-1]) && (sum[N-1] != A[N-1]), where B' is the inverted-if-sub operand.
- zero = ~|sum.
- Results emerge strictly in input order. No op is dropped or duplicated under any backpressure pattern.

## Timing
- Latency: an op accepted in cycle t appears on out_valid in cycle t+STAGES when not stalled.
- Throughput: one op per cycle while out_ready stays high.
- Reset: all stage valid bits clear. Data registers and sum/cout/ovf/zero clear to 0. in_ready=1 and out_valid=0 in the first cycle after reset.
- Reset mid-operation discards all in-flight ops, and nothing is emitted afterwards.
- Full pipeline with out_ready=0: in_ready=0, and outputs hold stable until accepted.
- A simultaneous accept at the input and release at the output when full completes both in the same cycle, with no bubble.
- Outputs stay stable while out_valid && !out_ready (standard valid/ready rule).
- STAGES=1 degenerates to a single registered adder with latency 1.

## Configuration
- PIPE_ADDSUB_FLAGS_EN
  - Defined: ovf and zero are computed as above. Operand sign bits are carried to the last stage for ovf.
  - Undefined: ovf and zero are tied to 0. The sign-bit pipeline registers and the zero reduction are not built.
  - sum/cout behaviour is identical in both builds.

## Structure
- Shared package holds:
  - the slice-width localparam computation
  - the stage-register struct typedef (valid, partial sum, remaining A/B, carry, sign bits)
  - the op-encoding constants (OP_ADD=0, OP_SUB=1)
- One sub-module, addsub_slice: a W-bit combinational ripple slice built from the existing full-adder cell. It takes carry in and produces sum bits and carry out, and is instantiated once per stage via generate.
- Top level contains only stage registers, handshake logic and flag logic.

## Test plan
- N=32, STAGES=4: A=0x0000_0001, B=0xFFFF_FFFF, cin=0, sub=0 -> sum=0, cout=1, zero=1, ovf=0, out_valid 4 cycles after accept.
- A=0x7FFF_FFFF, B=1, add -> sum=0x8000_0000, ovf=1, cout=0. Then A=5, B=7, sub=1, cin=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Stream 100 random ops with out_ready=1 -> one result per cycle, in order, matching a reference model.
- Random out_ready toggling (~50%) with continuous in_valid -> no loss, duplication or reorder. Outputs stay stable while stalled. in_ready drops only when all 4 stages are full.
- Assert rst with 3 ops in flight -> out_valid=0 next cycle, and no stale result ever appears afterwards.
- STAGES=1 and STAGES=32 builds -> latency 1 and 32 respectively with correct sums. With PIPE_ADDSUB_FLAGS_EN undefined, ovf=zero=0 always.
